approx_mult_err_monitor: RTL
============================

// Module: approx_mult_err_monitor
// PURPOSE
//   Consumer side of the 8x8 approximate multipliers. It takes operand pairs
//   and the approximate 16-bit product from the multiplier under test. It
//   recomputes the exact product and accumulates error metrics over a
//   programmed window of N samples: error count (ER), sum of error distance
//   (for MED), and maximum error distance with the operands that caused it.
//   It sits between the stimulus sweep and the result readout in the
//   characterisation harness.
// PARAMETERS
//   CNT_W   17   width of sample counters; 17 allows a full 65536-pair sweep
//   SUM_W   40   width of sum_ed accumulator; saturates, never wraps
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      1-cycle pulse; begins a window (ignored when busy)
//   num_samples  in   CNT_W  window length N, sampled on accepted start
//   in_valid     in   1      a/b/r valid this cycle
//   in_ready     out  1      monitor accepts a sample this cycle
//   a            in   8      operand A presented to the multiplier
//   b            in   8      operand B presented to the multiplier
//   r            in   16     approximate product returned by the multiplier
//   busy         out  1      high in RUN and DRAIN
//   done         out  1      1-cycle pulse; results final
//   sample_cnt   out  CNT_W  samples accumulated so far
//   err_cnt      out  CNT_W  samples with ed != 0
//   sum_ed       out  SUM_W  sum of ed, saturating at all-ones
//   max_ed       out  16     largest ed seen
//   max_a        out  8      a of the first sample reaching max_ed
//   max_b        out  8      b of the first sample reaching max_ed
// BEHAVIOUR
//   Reset: state IDLE, pipeline valids cleared, all outputs 0, applied
//     asynchronously. Deassertion takes effect at the next clk edge.
//   FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: in_ready=0, busy=0.
//     start=1 with N!=0: clear all result regs, latch N, go to RUN.
//     start=1 with N==0: clear all result regs, go to DONE.
//   RUN: in_ready = (accepted < N). A sample is accepted when in_valid &&
//     in_ready. When accepted reaches N, go to DRAIN. in_ready is 0 from the
//     cycle after the Nth accept. Gaps in in_valid are allowed.
//   Pipeline, fixed latency 2 cycles from accept to result regs:
//     S1: register exact = a*b (16 b unsigned), r, a, b, valid.
//     S2: ed = |exact - r| (16 b unsigned, either sign).
//       sample_cnt += 1.
//       err_cnt += (ed != 0).
//       sum_ed = min(sum_ed + ed, 2^SUM_W - 1).
//       If ed > max_ed (strict): max_ed = ed, max_a = a, max_b = b.
//   DRAIN: stay until both pipeline valids are 0, then go to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE. Results hold until the
//     next accepted start.
//   start while busy=1 or in DONE: ignored, with no effect on counts.
//   in_valid outside RUN: ignored, nothing accepted.
//   Results are readable at any time; they are final only at done.
// TESTING
//   1 N=4, r=a*b exact for (3,5),(255,255),(0,9),(128,2) -> done; counts:
//     sample 4, err 0, sum_ed 0, max_ed 0.
//   2 N=3, (15,15,r=200), (255,255,r=65025), (16,16,r=300) -> err 2,
//     sum 69, max_ed 44, max_a 16, max_b 16.
//   3 N=1, (2,3,r=10), r above exact -> ed 4, err 1, sum 4.
//   4 N=0 start -> done at cycle 2 after start; in_ready never 1; counts 0.
//   5 N=65536 exhaustive sweep with in_valid toggling every other cycle,
//     r exact -> sample 65536, in_ready low after last accept.
//   6 rst_n low mid-RUN -> all outputs 0 immediately. Second: start pulsed
//     mid-RUN -> ignored, window ends at original N.
//   7 SUM_W=8, N=2, ed 200 and 100 -> sum_ed 255 (saturated).

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// Error monitor for 8x8 approximate multipliers.
// Recomputes the exact product of each accepted operand pair and accumulates
// error statistics over a window of N samples: error count, saturating sum of
// error distance, and the largest error distance along with its operands.
module approx_mult_err_monitor #(
    parameter int CNT_W = 17,
    parameter int SUM_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      r,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_ed,
    output logic [15:0]      max_ed,
    output logic [7:0]       max_a,
    output logic [7:0]       max_b
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Extended width so sum + ed never wraps, even when SUM_W is narrower than ed.
    localparam int EXT_W = ((SUM_W > 16) ? SUM_W : 16) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    state_t           state_reg;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] acc_cnt_reg;
    logic             done_reg;

    // Stage 1: exact product and raw sample
    logic             v1_reg;
    logic [15:0]      exact1_reg;
    logic [15:0]      r1_reg;
    logic [7:0]       a1_reg;
    logic [7:0]       b1_reg;

    // Stage 2: error distance
    logic             v2_reg;
    logic [15:0]      ed2_reg;
    logic [7:0]       a2_reg;
    logic [7:0]       b2_reg;

    // Result registers
    logic [CNT_W-1:0] sample_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [SUM_W-1:0] sum_ed_reg;
    logic [15:0]      max_ed_reg;
    logic [7:0]       max_a_reg;
    logic [7:0]       max_b_reg;

    logic             accept;
    logic             clear_results;
    logic [15:0]      exact_next;
    logic [15:0]      ed_next;
    logic [EXT_W-1:0] sum_ext;
    logic [SUM_W-1:0] sum_next;

    assign in_ready      = (state_reg == RUN) && (acc_cnt_reg < n_reg);
    assign accept        = in_valid && in_ready;
    assign busy          = (state_reg == RUN) || (state_reg == DRAIN);
    assign done          = done_reg;
    assign clear_results = (state_reg == IDLE) && start;

    assign exact_next = {8'd0, a} * {8'd0, b};
    assign ed_next    = (exact1_reg >= r1_reg) ? (exact1_reg - r1_reg) : (r1_reg - exact1_reg);

    assign sum_ext  = EXT_W'(sum_ed_reg) + EXT_W'(ed2_reg);
    assign sum_next = (sum_ext > EXT_W'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_W-1:0];

    assign sample_cnt = sample_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign sum_ed     = sum_ed_reg;
    assign max_ed     = max_ed_reg;
    assign max_a      = max_a_reg;
    assign max_b      = max_b_reg;

    // Window control: latch N, count accepts, wait for pipeline drain, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            n_reg       <= '0;
            acc_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_cnt_reg <= '0;
                        if (num_samples != '0) begin
                            n_reg     <= num_samples;
                            state_reg <= RUN;
                        end else begin
                            n_reg     <= '0;
                            state_reg <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
                        if (acc_cnt_reg + CNT_W'(1) == n_reg)
                            state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!v1_reg && !v2_reg)
                        state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Two-stage datapath: exact product, then absolute error distance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg     <= 1'b0;
            exact1_reg <= '0;
            r1_reg     <= '0;
            a1_reg     <= '0;
            b1_reg     <= '0;
            v2_reg     <= 1'b0;
            ed2_reg    <= '0;
            a2_reg     <= '0;
            b2_reg     <= '0;
        end else begin
            v1_reg <= accept;
            if (accept) begin
                exact1_reg <= exact_next;
                r1_reg     <= r;
                a1_reg     <= a;
                b1_reg     <= b;
            end
            v2_reg <= v1_reg;
            if (v1_reg) begin
                ed2_reg <= ed_next;
                a2_reg  <= a1_reg;
                b2_reg  <= b1_reg;
            end
        end
    end

    // Accumulate metrics; cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_reg <= '0;
            err_cnt_reg    <= '0;
            sum_ed_reg     <= '0;
            max_ed_reg     <= '0;
            max_a_reg      <= '0;
            max_b_reg      <= '0;
        end else if (clear_results) begin
            sample_cnt_reg <= '0;
            err_cnt_reg    <= '0;
            sum_ed_reg     <= '0;
            max_ed_reg     <= '0;
            max_a_reg      <= '0;
            max_b_reg      <= '0;
        end else if (v2_reg) begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
            if (ed2_reg != 16'd0)
                err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            sum_ed_reg <= sum_next;
            // Strict compare keeps the operands of the first sample reaching the max
            if (ed2_reg > max_ed_reg) begin
                max_ed_reg <= ed2_reg;
                max_a_reg  <= a2_reg;
                max_b_reg  <= b2_reg;
            end
        end
    end

endmodule
